key_display_buffer: RTL

Downstream consumer of the 4×4 keypad scanner. It accepts one-cycle key events (`key_valid`, `key_code`) and keeps a 4-digit entry buffer that supports hex entry, backspace and clear. It time-multiplexes the buffer onto a common-anode 4-digit 7-segment display through `digit` and `seg`. Unfilled positions are blanked, and the raw buffer is exported for other consumers.

---
 rtl/key_display_buffer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/key_display_buffer.sv
// -----------------------------------------------------------------------------
// key_display_buffer
//
// Sits behind the 4x4 keypad scanner. Collects hex digits into a four-nibble
// entry buffer (with backspace and clear) and time-multiplexes that buffer onto
// a common-anode 4-digit 7-segment display. Positions that hold no entered
// digit are blanked. The raw buffer and the digit count are exported for other
// consumers.
//
// Parameters
//   SCAN_DIV   clock cycles each digit position is driven (>= 1)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   key_valid  one-cycle key event strobe
//   key_code   0x0-0xD hex digit, 0xE backspace, 0xF clear
//   digit      digit enables, active-low one-hot, bit 0 = newest position
//   seg        segments, active-low, {dp,g,f,e,d,c,b,a}
//   value      buffer contents, [3:0] = newest nibble
//   count      number of entered digits, 0-4
//
// Handshake: key_valid is a plain strobe with no back-pressure. Every cycle it
// is high is one key event, and key_code is sampled on that same rising edge.
// -----------------------------------------------------------------------------
module key_display_buffer #(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [3:0]  digit,
    output logic [7:0]  seg,
    output logic [15:0] value,
    output logic [2:0]  count
);

    // A one-bit counter is kept even for SCAN_DIV=1. It then sits at 0, which
    // equals CNT_MAX, so idx advances every cycle.
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    localparam logic [3:0] KEY_BKSP  = 4'hE;
    localparam logic [3:0] KEY_CLEAR = 4'hF;
    localparam logic [2:0] COUNT_MAX = 3'd4;

    // Entry buffer: nib_q[0] is the newest digit, nib_q[3] the oldest.
    logic [3:0]       nib_q [4];
    logic [3:0]       nib_d [4];
    logic [2:0]       count_q, count_d;

    // Scan state.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;

    // Registered display outputs.
    logic [3:0]       digit_q, digit_d;
    logic [7:0]       seg_q, seg_d;

    // Hex to active-low 7-segment ({dp,g,f,e,d,c,b,a}). dp stays off.
    // Codes E and F never reach the display because they are commands, not
    // digits, so they decode to blank.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Key handling
    // Slots at or above count always hold zero. Reset and clear zero every
    // slot, entry shifts the existing contents up, and backspace shifts a zero
    // in at the top. Because of that, backspace on an empty buffer can shift
    // unconditionally and still leave the buffer unchanged.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nib_d[i] = nib_q[i];
        end
        count_d = count_q;

        if (key_valid) begin
            if (key_code == KEY_CLEAR) begin
                for (int i = 0; i < 4; i++) begin
                    nib_d[i] = 4'h0;
                end
                count_d = 3'd0;
            end else if (key_code == KEY_BKSP) begin
                nib_d[0] = nib_q[1];
                nib_d[1] = nib_q[2];
                nib_d[2] = nib_q[3];
                nib_d[3] = 4'h0;
                count_d  = (count_q == 3'd0) ? 3'd0 : count_q - 3'd1;
            end else begin
                // Hex digit: the oldest digit falls off the top once the
                // buffer is full.
                nib_d[3] = nib_q[2];
                nib_d[2] = nib_q[1];
                nib_d[1] = nib_q[0];
                nib_d[0] = key_code;
                count_d  = (count_q == COUNT_MAX) ? COUNT_MAX : count_q + 3'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Scan sequencing: hold each position for SCAN_DIV cycles, in order 0..3.
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Display drive. This uses the pre-edge idx and buffer, so digit/seg lag
    // idx by one cycle and a key shows on the display no earlier than the edge
    // after it is accepted.
    // -------------------------------------------------------------------------
    always_comb begin
        digit_d = ~(4'b0001 << idx_q);
        if ({1'b0, idx_q} < count_q) begin
            seg_d = hex_to_seg(nib_q[idx_q]);
        end else begin
            seg_d = 8'hFF;
        end
    end

    // -------------------------------------------------------------------------
    // State registers. Reset wins over a simultaneous key event.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                nib_q[i] <= 4'h0;
            end
            count_q <= 3'd0;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            digit_q <= 4'b1111;
            seg_q   <= 8'hFF;
        end else begin
            for (int i = 0; i < 4; i++) begin
                nib_q[i] <= nib_d[i];
            end
            count_q <= count_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
        end
    end

    assign digit = digit_q;
    assign seg   = seg_q;
    assign value = {nib_q[3], nib_q[2], nib_q[1], nib_q[0]};
    assign count = count_q;

endmodule
